led_right_to_left: RTL and testbench
====================================

# led_right_to_left

Right-to-left LED chaser for the 8-LED board bank: a single lit LED walks from LED8[0] to LED8[7], holds at the MSB end, then wraps back to LED8[0]. It runs in the opposite direction to the team's existing left-to-right chaser and shares its clk/reset/LED8 interface, so a top level can select either pattern. A built-in prescaler sets the step rate, a run input pauses it, and a one-cycle wrap pulse marks the end of each sweep.

## Interface
- TICK_DIV, default 4: clk cycles per LED step; legal range ≥ 2. Board builds set it to 50_000_000.
- END_HOLD, default 2: number of steps the pattern dwells at the end position before wrapping; legal range ≥ 1.
- clk  input  1  single system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  1 = advance; 0 = freeze the prescaler, state and LED8.
- LED8  output  8  LED drive, registered; bit 0 is the rightmost LED.
- wrap_pulse  output  1  registered; high for exactly one clk when the pattern wraps to 8'h01.

## Operation
- Prescaler: counter `div_cnt` runs 0..TICK_DIV-1 while run=1.
  - `tick` is asserted in the cycle where div_cnt == TICK_DIV-1 and run=1; div_cnt returns to 0 on that cycle.
  - run=0 holds div_cnt at its current value and produces no tick.
- FSM states:
  - IDLE: LED8 = 8'h00. On tick → SHIFT, LED8 <= 8'h01.
  - SHIFT: on tick, LED8 <= {LED8[6:0],1'b0}. A tick that loads 8'h80 also moves → HOLD and clears hold_cnt.
  - HOLD: LED8 stays at its end value. On tick, if hold_cnt == END_HOLD-1 → SHIFT, LED8 <= 8'h01, wrap_pulse <= 1; otherwise hold_cnt++.
- wrap_pulse is 0 in every other cycle.
- Exactly one bit of LED8 is set outside IDLE; this is the default build.
- hold_cnt is wide enough for END_HOLD-1. div_cnt is $clog2(TICK_DIV) bits. No counter ever wraps past its terminal value.

## Timing
- Reset values: LED8 = 8'h00, wrap_pulse = 0, div_cnt = 0, hold_cnt = 0, state IDLE.
- Reset takes priority over run and tick in the same cycle. Reset mid-sweep returns to IDLE on the next edge, and the sweep restarts from 8'h01 after TICK_DIV running cycles.
- Latency: with run=1 from the first edge after reset, LED8 = 8'h01 after TICK_DIV edges and LED8 = 8'h80 after 8·TICK_DIV edges.
- The end value is held for END_HOLD·TICK_DIV cycles. Wrap occurs at edge (8+END_HOLD)·TICK_DIV; each later sweep period is (7+END_HOLD)·TICK_DIV.
- wrap_pulse rises on the same edge that loads 8'h01 after HOLD. It does not fire on the initial IDLE→SHIFT transition.
- Toggling run: pausing for N cycles delays every later event by exactly N cycles. A run=0 in the tick cycle suppresses that tick.

## Configuration
- LED_FILL_EN defined: bar-graph fill mode.
  - SHIFT does LED8 <= {LED8[6:0],1'b1}, so the sequence is 01, 03, 07 … FF.
  - HOLD is entered when 8'hFF is loaded. Wrap reloads 8'h01.
  - All timing is identical to the default build.
- LED_FILL_EN undefined: single-dot chaser as described above.

## Test plan
- Reset/idle: hold reset for 3 cycles with run=1 → LED8 = 8'h00 and wrap_pulse = 0 throughout; after release with TICK_DIV=4, LED8 = 8'h01 exactly at edge 4.
- Full sweep: TICK_DIV=4, END_HOLD=2, run=1 → LED8 = 01, 02, 04 … 80 at edges 4, 8 … 32; 8'h80 held through edge 39; LED8 = 8'h01 with wrap_pulse = 1 at edge 40 only; next wrap at edge 76.
- Pause: drop run for 10 cycles while LED8 = 8'h04 → LED8 and div_cnt frozen; 8'h08 appears exactly 10 cycles later than it would without the pause.
- Reset mid-operation: assert reset for 1 cycle in HOLD → next edge LED8 = 8'h00 and wrap_pulse = 0; the sweep restarts with 8'h01 after 4 cycles.
- Reset vs tick collision: reset asserted in the same cycle as a tick → reset wins and LED8 = 8'h00.
- LED_FILL_EN build: same stimulus as the full-sweep test → LED8 = 01, 03, 07 … FF at edges 4 … 32; wrap to 8'h01 with wrap_pulse at edge 40.

Source files
------------

// File: rtl/led_right_to_left.sv
// Right-to-left LED chaser: one lit LED walks LED8[0] -> LED8[7], dwells, then wraps.
// Define LED_FILL_EN for bar-graph fill mode (01, 03, 07 ... FF) with identical timing.
module led_right_to_left #(
  parameter int TICK_DIV = 4,
  parameter int END_HOLD = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic [7:0] LED8,
  output logic       wrap_pulse,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DW = $clog2(TICK_DIV);
  localparam int HW = (END_HOLD > 1) ? $clog2(END_HOLD) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(END_HOLD - 1);

`ifdef LED_FILL_EN
  localparam logic       FILL    = 1'b1;
  localparam logic [7:0] END_VAL = 8'hFF;
`else
  localparam logic       FILL    = 1'b0;
  localparam logic [7:0] END_VAL = 8'h80;
`endif

  state_t          state;
  logic [DW-1:0]   div_cnt;
  logic [HW-1:0]   hold_cnt;
  logic            tick;
  logic [7:0]      shifted;

  // The prescaler stalls outright while run is low, so pauses delay every later event.
  assign tick      = run && (div_cnt == DIV_LAST);
  assign shifted   = {LED8[6:0], FILL};
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      div_cnt    <= '0;
      hold_cnt   <= '0;
      LED8       <= 8'h00;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (run) begin
        div_cnt <= tick ? '0 : div_cnt + DW'(1);
      end
      if (tick) begin
        case (state)
          IDLE: begin
            state <= SHIFT;
            LED8  <= 8'h01;
          end
          SHIFT: begin
            LED8 <= shifted;
            if (shifted == END_VAL) begin
              state    <= HOLD;
              hold_cnt <= '0;
            end
          end
          HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              state      <= SHIFT;
              LED8       <= 8'h01;
              wrap_pulse <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          default: begin
            state <= IDLE;
            LED8  <= 8'h00;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_right_to_left.sv
// Bench for led_right_to_left: a position-from-running-time reference model feeds an
// expected queue at each drive; a posedge monitor pops and compares LED8 and wrap_pulse.
module tb_led_right_to_left;

  localparam int TD = 4;
  localparam int EH = 2;

  logic       clk;
  logic       reset;
  logic       run;
  logic [7:0] LED8;
  logic       wrap_pulse;
  logic [1:0] dbg_state;

  logic [8:0] exp_q[$];
  int compared;
  int mismatched;
  int run_cycles;
  logic [7:0] last_led;

  led_right_to_left #(.TICK_DIV(TD), .END_HOLD(EH)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .LED8       (LED8),
    .wrap_pulse (wrap_pulse),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: LED position is a pure function of running cycles since reset.
  function automatic logic [7:0] model_led(input int r);
    int k;
    int m;
    int idx;
    k = r / TD;
    if (k == 0) return 8'h00;
    m   = (k - 1) % (7 + EH);
    idx = (m > 7) ? 7 : m;
`ifdef LED_FILL_EN
    return 8'((2 << idx) - 1);
`else
    return 8'(1 << idx);
`endif
  endfunction

  function automatic logic model_wrap(input int r);
    int k;
    k = r / TD;
    return (r % TD == 0) && (k > 1) && (((k - 1) % (7 + EH)) == 0);
  endfunction

  // Driver: apply inputs at negedge and push the expected post-edge outputs.
  task automatic step(input logic rst, input logic rn);
    logic [7:0] e_led;
    logic       e_wrap;
    @(negedge clk);
    reset = rst;
    run   = rn;
    if (rst) begin
      run_cycles = 0;
      e_led  = 8'h00;
      e_wrap = 1'b0;
    end else if (rn) begin
      run_cycles++;
      e_led  = model_led(run_cycles);
      e_wrap = model_wrap(run_cycles);
    end else begin
      e_led  = last_led;
      e_wrap = 1'b0;
    end
    last_led = e_led;
    exp_q.push_back({e_wrap, e_led});
  endtask

  // Monitor / scoreboard
  always @(posedge clk) begin
    logic [8:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (LED8 !== e[7:0]) begin
        mismatched++;
        $display("FAIL led8 @%0t: got %h expected %h", $time, LED8, e[7:0]);
      end
      compared++;
      if (wrap_pulse !== e[8]) begin
        mismatched++;
        $display("FAIL wrap_pulse @%0t: got %b expected %b", $time, wrap_pulse, e[8]);
      end
    end
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    run_cycles = 0;
    last_led   = 8'h00;
    reset      = 1'b1;
    run        = 1'b1;

    // Reset held 3 cycles with run high, then two full sweeps (wraps at 40 and 76).
    repeat (3) step(1'b1, 1'b1);
    repeat (80) step(1'b0, 1'b1);

    // Pause while LED8 = 04 for 10 cycles.
    step(1'b1, 1'b1);
    repeat (13) step(1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0);
    repeat (12) step(1'b0, 1'b1);

    // Reset during HOLD, then restart.
    step(1'b1, 1'b1);
    repeat (35) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (10) step(1'b0, 1'b1);

    // Reset on the cycle that would tick.
    step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (6) step(1'b0, 1'b1);

    // Randomized run toggling with occasional resets.
    repeat (2000) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0));
    end
    repeat (3) step(1'b0, 1'b1);

    // Drain with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
